// File: rtl/controlador_codificador.sv
// Arbitrates two nibble requesters round-robin, drives an external encoder for
// one cycle, captures its code word and holds it until the consumer acknowledges.
module controlador_codificador (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic [3:0] data0,
    input  logic       req1,
    input  logic [3:0] data1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       enc_a,
    output logic       enc_b,
    output logic       enc_c,
    output logic       enc_d,
    output logic       enc_ready,
    input  logic [3:0] enc_s,
    output logic [3:0] out_code,
    output logic       out_src,
    output logic       out_valid,
    input  logic       out_ack,
    output logic       busy,
    output logic [7:0] done_cnt,
    output logic [1:0] dbg_state
);

    // Handshake: req/data are held by the requester until its one-cycle gnt;
    // out_code/out_src are presented with out_valid and held until out_ack is
    // sampled high in HOLD. out_ack seen in any other state is ignored.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] data_reg;
    logic       prio;
    logic       pick1;

    // prio = 1 means requester 1 wins a tie; a lone request always wins.
    always_comb begin
        pick1 = req1 & (~req0 | prio);
    end

    assign enc_a     = data_reg[3];
    assign enc_b     = data_reg[2];
    assign enc_c     = data_reg[1];
    assign enc_d     = data_reg[0];
    assign dbg_state = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            data_reg  <= 4'd0;
            prio      <= 1'b0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            enc_ready <= 1'b0;
            out_code  <= 4'd0;
            out_src   <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done_cnt  <= 8'd0;
        end else begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 | req1) begin
                        data_reg  <= pick1 ? data1 : data0;
                        out_src   <= pick1;
                        gnt0      <= ~pick1;
                        gnt1      <= pick1;
                        enc_ready <= 1'b1;
                        busy      <= 1'b1;
                        state     <= DRIVE;
                    end
                end
                DRIVE: begin
                    // The encoder has had a full cycle to settle on data_reg.
                    out_code  <= enc_s;
                    out_valid <= 1'b1;
                    enc_ready <= 1'b0;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (out_ack) begin
                        out_valid <= 1'b0;
                        done_cnt  <= done_cnt + 8'd1;
                        prio      <= ~out_src;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    enc_ready <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_controlador_codificador.sv
// Bench for controlador_codificador: fixed vector table, hand-written corner
// sequences and random transactions checked against a transaction-level model.
module tb_controlador_codificador;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1;
    logic [3:0] data0, data1;
    logic       gnt0, gnt1;
    logic       enc_a, enc_b, enc_c, enc_d;
    logic       enc_ready;
    logic [3:0] enc_s;
    logic [3:0] out_code;
    logic       out_src, out_valid, out_ack, busy;
    logic [7:0] done_cnt;
    logic [1:0] dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    int m_cnt   = 0;
    logic m_prio = 1'b0;
    int ready_cycles = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    controlador_codificador dut (
        .clk(clk), .reset(reset),
        .req0(req0), .data0(data0), .req1(req1), .data1(data1),
        .gnt0(gnt0), .gnt1(gnt1),
        .enc_a(enc_a), .enc_b(enc_b), .enc_c(enc_c), .enc_d(enc_d),
        .enc_ready(enc_ready), .enc_s(enc_s),
        .out_code(out_code), .out_src(out_src), .out_valid(out_valid),
        .out_ack(out_ack), .busy(busy), .done_cnt(done_cnt),
        .dbg_state(dbg_state)
    );

    // Stand-in encoder: a bijective nibble map with 0000 -> 1010.
    function automatic logic [3:0] enc_f(input logic [3:0] x);
        logic [7:0] t;
        t = {4'd0, x} * 8'd7 + 8'd10;
        return t[3:0];
    endfunction

    assign enc_s = enc_f({enc_a, enc_b, enc_c, enc_d});

    always @(posedge clk) begin
        if (reset && enc_ready) ready_cycles++;
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Round-robin rule: a lone request wins; a tie goes to the side not served last.
    function automatic logic model_pick(input logic r0, input logic r1);
        if (r0 && r1) return m_prio;
        return r1;
    endfunction

    task automatic do_reset();
        reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
        data0 = 4'd0; data1 = 4'd0; out_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_gnt", {gnt1, gnt0}, 0);
        check("rst_enc", {enc_a, enc_b, enc_c, enc_d, enc_ready}, 0);
        check("rst_out", {out_code, out_src, out_valid}, 0);
        check("rst_busy", busy, 0);
        check("rst_cnt", done_cnt, 0);
        check("rst_state", dbg_state, 0);
        reset = 1'b1;
        m_cnt = 0;
        m_prio = 1'b0;
    endtask

    // One complete transaction, starting and ending on a falling edge.
    task automatic txn(input logic r0, input logic r1, input logic [3:0] d0, input logic [3:0] d1,
                       input int stall, input logic exp_src, input logic [3:0] exp_code);
        logic [3:0] exp_data;
        exp_data = exp_src ? d1 : d0;
        req0 = r0; req1 = r1; data0 = d0; data1 = d1; out_ack = 1'b0;
        @(posedge clk); @(negedge clk);
        check("gnt0", gnt0, {31'd0, ~exp_src});
        check("gnt1", gnt1, {31'd0, exp_src});
        check("drive_ready", enc_ready, 1);
        check("drive_busy", busy, 1);
        check("drive_valid", out_valid, 0);
        check("drive_enc", {enc_a, enc_b, enc_c, enc_d}, exp_data);
        out_ack = (stall == 0);
        @(posedge clk); @(negedge clk);
        check("hold_valid", out_valid, 1);
        check("hold_code", out_code, exp_code);
        check("hold_src", out_src, exp_src);
        check("hold_gnt", {gnt1, gnt0}, 0);
        check("hold_ready", enc_ready, 0);
        check("hold_enc", {enc_a, enc_b, enc_c, enc_d}, exp_data);
        for (int i = 0; i < stall; i++) begin
            req1 = 1'($urandom_range(0, 1));
            @(posedge clk); @(negedge clk);
            check("stall_valid", out_valid, 1);
            check("stall_code", out_code, exp_code);
            check("stall_busy", busy, 1);
            check("stall_gnt", {gnt1, gnt0}, 0);
            check("stall_cnt", done_cnt, m_cnt % 256);
        end
        out_ack = 1'b1;
        @(posedge clk); @(negedge clk);
        m_cnt++;
        m_prio = ~exp_src;
        check("ack_valid", out_valid, 0);
        check("ack_busy", busy, 0);
        check("ack_gnt", {gnt1, gnt0}, 0);
        check("ack_cnt", done_cnt, m_cnt % 256);
        req0 = 1'b0; req1 = 1'b0; out_ack = 1'b0;
    endtask

    task automatic rand_txn(input logic r0, input logic r1, input int stall);
        logic [3:0] d0, d1;
        logic       s;
        d0 = 4'($urandom_range(0, 15));
        d1 = 4'($urandom_range(0, 15));
        s = model_pick(r0, r1);
        txn(r0, r1, d0, d1, stall, s, enc_f(s ? d1 : d0));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       r0;
        logic       r1;
        logic [3:0] d0;
        logic [3:0] d1;
        logic       exp_src;
        logic [3:0] exp_code;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 4'b1010};
        vecs[1] = '{1'b1, 1'b1, 4'h3, 4'h5, 1'b1, 4'd13};
        vecs[2] = '{1'b1, 1'b1, 4'h9, 4'h2, 1'b0, 4'd9};
        vecs[3] = '{1'b0, 1'b1, 4'h1, 4'hF, 1'b1, 4'd3};
        vecs[4] = '{1'b1, 1'b0, 4'h7, 4'h8, 1'b0, 4'd11};
        vecs[5] = '{1'b1, 1'b0, 4'hC, 4'h0, 1'b0, 4'd14};
        vecs[6] = '{1'b1, 1'b1, 4'h4, 4'h6, 1'b1, 4'd4};

        do_reset();
        for (int i = 0; i < 7; i++)
            txn(vecs[i].r0, vecs[i].r1, vecs[i].d0, vecs[i].d1, 0, vecs[i].exp_src, vecs[i].exp_code);

        // Backpressure: ten stalled cycles with stray req1 pulses.
        rand_txn(1'b1, 1'b0, 10);

        // Simultaneous requests from reset alternate 0,1,0,1.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            check("rr_order", model_pick(1'b1, 1'b1), i % 2);
            rand_txn(1'b1, 1'b1, 0);
        end
        check("rr_cnt4", done_cnt, 4);

        // Reset asserted in DRIVE aborts everything immediately.
        req0 = 1'b1; data0 = 4'hB;
        @(posedge clk); @(negedge clk);
        check("abort_pre_gnt", gnt0, 1);
        reset = 1'b0;
        #1;
        check("abort_gnt", {gnt1, gnt0}, 0);
        check("abort_enc", {enc_a, enc_b, enc_c, enc_d, enc_ready}, 0);
        check("abort_out", {out_code, out_src, out_valid}, 0);
        check("abort_busy", busy, 0);
        check("abort_cnt", done_cnt, 0);
        @(posedge clk); @(negedge clk);
        check("abort_held_gnt", {gnt1, gnt0}, 0);
        req0 = 1'b0; reset = 1'b1; out_ack = 1'b1;
        m_cnt = 0; m_prio = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_ack_valid", out_valid, 0);
        check("idle_ack_busy", busy, 0);
        check("idle_ack_cnt", done_cnt, 0);
        out_ack = 1'b0;

        // Every nibble through requester 1; one enc_ready cycle per word.
        ready_cycles = 0;
        for (int v = 0; v < 16; v++)
            txn(1'b0, 1'b1, 4'd0, 4'(v), 0, 1'b1, enc_f(4'(v)));
        check("sweep_ready_cycles", ready_cycles, 16);

        // Random mix.
        for (int i = 0; i < 40; i++) begin
            logic r0, r1;
            r0 = 1'($urandom_range(0, 1));
            r1 = 1'($urandom_range(0, 1));
            if (!r0 && !r1) r0 = 1'b1;
            rand_txn(r0, r1, $urandom_range(0, 3));
        end

        // Counter wrap after 256 transactions.
        do_reset();
        for (int i = 0; i < 256; i++)
            rand_txn(1'b1, 1'b0, 0);
        check("wrap_cnt", done_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
